// File: rtl/axi_interface_slave_mem_if.sv
// AXI4 slave-side bus bundle for axi_interface_slave_mem: AW/W/B/AR/R channels with master and slave views.
interface axi_interface_slave_mem_if #(
  parameter int ID_BITS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3
);
  logic [ID_BITS-1:0]      s_awid;
  logic [ADDR_WIDTH-1:0]   s_awaddr;
  logic [LEN_BITS-1:0]     s_awlen;
  logic [SIZE_BITS-1:0]    s_awsize;
  logic [1:0]              s_awburst;
  logic                    s_awvalid;
  logic                    s_awready;
  logic [DATA_WIDTH-1:0]   s_wdata;
  logic [DATA_WIDTH/8-1:0] s_wstrb;
  logic                    s_wlast;
  logic                    s_wvalid;
  logic                    s_wready;
  logic [ID_BITS-1:0]      s_bid;
  logic [1:0]              s_bresp;
  logic                    s_bvalid;
  logic                    s_bready;
  logic [ID_BITS-1:0]      s_arid;
  logic [ADDR_WIDTH-1:0]   s_araddr;
  logic [LEN_BITS-1:0]     s_arlen;
  logic [SIZE_BITS-1:0]    s_arsize;
  logic [1:0]              s_arburst;
  logic                    s_arvalid;
  logic                    s_arready;
  logic [ID_BITS-1:0]      s_rid;
  logic [DATA_WIDTH-1:0]   s_rdata;
  logic [1:0]              s_rresp;
  logic                    s_rlast;
  logic                    s_rvalid;
  logic                    s_rready;

  modport slave (
    input  s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    output s_awready,
    input  s_wdata, s_wstrb, s_wlast, s_wvalid,
    output s_wready,
    output s_bid, s_bresp, s_bvalid,
    input  s_bready,
    input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    output s_arready,
    output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  s_rready
  );

  modport master (
    output s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awvalid,
    input  s_awready,
    output s_wdata, s_wstrb, s_wlast, s_wvalid,
    input  s_wready,
    input  s_bid, s_bresp, s_bvalid,
    output s_bready,
    output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
    input  s_arready,
    input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output s_rready
  );
endinterface

// File: rtl/axi_interface_slave_mem.sv
// AXI4 slave to single-beat req/ack memory port, one burst in flight; address/ack -> next stage in 1 cycle, W/R/B/ack stalls hold state.
// Optional window decode with DECERR under AXI_SLV_RANGE_CHECK_EN.
module axi_interface_slave_mem #(
  parameter int ID_BITS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_BITS   = 8,
  parameter int SIZE_BITS  = 3,
  parameter int BASE_ADDR  = 0,
  parameter int WIN_BYTES  = 4096
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  axi_interface_slave_mem_if.slave axi,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_MEM, WR_RESP, RD_MEM, RD_DATA} state_t;

  state_t                  r_state, w_next;
  logic                    r_rr, r_err;
  logic [ID_BITS-1:0]      r_id;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_BITS-1:0]     r_len, r_cnt;
  logic [SIZE_BITS-1:0]    r_size;
  logic [1:0]              r_burst, r_bad;
  logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
  logic [DATA_WIDTH/8-1:0] r_wstrb;

  logic                  w_idle, w_awready, w_arready, w_wready;
  logic                  w_aw_hs, w_ar_hs, w_w_hs, w_r_hs;
  logic                  w_last, w_bypass, w_mem_done, w_range_bad;
  logic                  w_mem_req, w_mem_we, w_bvalid, w_rvalid;
  logic [ADDR_WIDTH-1:0] w_acc_addr, w_addr_nxt;
  logic [1:0]            w_acc_burst, w_acc_bad;

  assign w_idle    = (r_state == IDLE) & ~rst_i;
  assign w_awready = w_idle & (~axi.s_arvalid | r_rr);
  assign w_arready = w_idle & (~axi.s_awvalid | ~r_rr);
  assign w_wready  = (r_state == WR_DATA) & ~rst_i;
  assign w_aw_hs   = axi.s_awvalid & w_awready;
  assign w_ar_hs   = axi.s_arvalid & w_arready;
  assign w_w_hs    = axi.s_wvalid & w_wready;
  assign w_r_hs    = w_rvalid & axi.s_rready;

  assign w_last     = (r_cnt == r_len);
  assign w_bypass   = (r_bad != 2'b00);
  assign w_mem_done = w_bypass | mem_ack_i;
  assign w_addr_nxt = (r_burst == 2'b01) ? r_addr + (ADDR_WIDTH'(1) << r_size) : r_addr;

  assign w_acc_addr  = w_ar_hs ? axi.s_araddr : axi.s_awaddr;
  assign w_acc_burst = w_ar_hs ? axi.s_arburst : axi.s_awburst;

`ifdef AXI_SLV_RANGE_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] LP_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LP_WIN  = ADDR_WIDTH'(WIN_BYTES);
  assign w_range_bad = (w_acc_addr < LP_BASE) | ((w_acc_addr - LP_BASE) >= LP_WIN);
  assign mem_addr_o  = r_addr - LP_BASE;
`else
  assign w_range_bad = 1'b0;
  assign mem_addr_o  = r_addr;
`endif

  // Decode error outranks an unsupported burst type; either one keeps the burst off the memory port.
  assign w_acc_bad = w_range_bad ? 2'b11 : (w_acc_burst[1] ? 2'b10 : 2'b00);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_bvalid  = 1'b0;
    w_rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_aw_hs)      w_next = WR_DATA;
        else if (w_ar_hs) w_next = RD_MEM;
      end
      WR_DATA: if (w_w_hs) w_next = WR_MEM;
      WR_MEM: begin
        w_mem_req = ~w_bypass & ~rst_i;
        w_mem_we  = ~rst_i;
        if (w_mem_done) w_next = w_last ? WR_RESP : WR_DATA;
      end
      WR_RESP: begin
        w_bvalid = ~rst_i;
        if (axi.s_bready) w_next = IDLE;
      end
      RD_MEM: begin
        w_mem_req = ~w_bypass & ~rst_i;
        if (w_mem_done) w_next = RD_DATA;
      end
      RD_DATA: begin
        w_rvalid = ~rst_i;
        if (axi.s_rready) w_next = w_last ? IDLE : RD_MEM;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rr    <= 1'b0;
      r_err   <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_bad   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else begin
      if (w_aw_hs | w_ar_hs) begin
        r_rr    <= ~r_rr;
        r_id    <= w_ar_hs ? axi.s_arid : axi.s_awid;
        r_addr  <= w_acc_addr;
        r_len   <= w_ar_hs ? axi.s_arlen : axi.s_awlen;
        r_size  <= w_ar_hs ? axi.s_arsize : axi.s_awsize;
        r_burst <= w_acc_burst;
        r_bad   <= w_acc_bad;
        r_cnt   <= '0;
        r_err   <= 1'b0;
      end
      if (w_w_hs) begin
        r_wdata <= axi.s_wdata;
        r_wstrb <= axi.s_wstrb;
        // The beat counter ends the burst; a misplaced WLAST only taints the response.
        if (axi.s_wlast != w_last) r_err <= 1'b1;
      end
      if ((r_state == RD_MEM) & w_mem_done)
        r_rdata <= w_bypass ? '0 : mem_rdata_i;
      if (((r_state == WR_MEM) & w_mem_done & ~w_last) | (w_r_hs & ~w_last)) begin
        r_cnt  <= r_cnt + 1'b1;
        r_addr <= w_addr_nxt;
      end
    end
  end

  assign axi.s_awready = w_awready;
  assign axi.s_arready = w_arready;
  assign axi.s_wready  = w_wready;
  assign axi.s_bvalid  = w_bvalid;
  assign axi.s_bid     = r_id;
  assign axi.s_bresp   = w_bypass ? r_bad : {r_err, 1'b0};
  assign axi.s_rvalid  = w_rvalid;
  assign axi.s_rid     = r_id;
  assign axi.s_rdata   = r_rdata;
  assign axi.s_rresp   = r_bad;
  assign axi.s_rlast   = w_rvalid & w_last;

  assign mem_req_o   = w_mem_req;
  assign mem_we_o    = w_mem_we;
  assign mem_wdata_o = r_wdata;
  assign mem_wstrb_o = r_wstrb;

endmodule
